// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand selection with RAW-hazard handling.
// Define EX_FORWARDING_EN for MEM/WB forwarding; otherwise dependent instructions stall.
module ex_operand_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OPCODE_LENGTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rd1,
  input  logic [DATA_WIDTH-1:0]     id_rd2,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alusrc,
  input  logic [OPCODE_LENGTH-1:0]  id_operation,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      ex_flush,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      mem_regwrite,
  input  logic                      wb_regwrite,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_regwrite,
  output logic                      ex_memread,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      stall
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alusrc;
    logic [OPCODE_LENGTH-1:0]  operation;
    logic                      regwrite;
    logic                      memread;
  } ex_reg_t;

  ex_reg_t ex_d, ex_q;

  logic                  hazard;
  logic                  ex_rd_hit;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  // Does the instruction currently in EX write a register that ID reads?
  assign ex_rd_hit = (ex_q.rd != '0) && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

`ifdef EX_FORWARDING_EN
  always_comb begin
    hazard = id_valid && ex_q.valid && ex_q.memread && ex_rd_hit;
  end

  always_comb begin
    fwd_a = ex_q.rd1;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_q.rs1)) begin
      fwd_a = mem_result;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_q.rs1)) begin
      fwd_a = wb_result;
    end
  end

  always_comb begin
    fwd_b = ex_q.rd2;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_q.rs2)) begin
      fwd_b = mem_result;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_q.rs2)) begin
      fwd_b = wb_result;
    end
  end
`else
  logic mem_rd_hit;
  logic unused_fwd;

  assign mem_rd_hit = (mem_rd != '0) && ((mem_rd == id_rs1) || (mem_rd == id_rs2));

  // WB is covered by register-file write-through, so only EX and MEM can stall.
  always_comb begin
    hazard = id_valid && ((ex_q.regwrite && ex_rd_hit) || (mem_regwrite && mem_rd_hit));
  end

  always_comb begin
    fwd_a = ex_q.rd1;
    fwd_b = ex_q.rd2;
  end

  assign unused_fwd = ^{wb_rd, wb_regwrite, wb_result, mem_result, ex_q.rs1, ex_q.rs2};
`endif

  assign stall = hazard && !ex_flush;

  always_comb begin
    ex_d = '0;
    if (!ex_flush && !stall) begin
      ex_d.valid     = id_valid;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.rd1       = id_rd1;
      ex_d.rd2       = id_rd2;
      ex_d.imm       = id_imm;
      ex_d.alusrc    = id_alusrc;
      ex_d.operation = id_operation;
      ex_d.regwrite  = id_valid && id_regwrite;
      ex_d.memread   = id_valid && id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign SrcA          = fwd_a;
  assign SrcB          = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign Operation     = ex_q.operation;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: scoreboard of expected EX register contents
// plus directed hazard/forwarding scenarios. Honours EX_FORWARDING_EN like the design.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic        id_alusrc;
  logic [3:0]  id_operation;
  logic        id_regwrite, id_memread;
  logic        ex_flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite;
  logic [31:0] mem_result, wb_result;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic        ex_valid, ex_regwrite, ex_memread, stall;
  logic [4:0]  ex_rd;

  ex_operand_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_rd1       (id_rd1),
    .id_rd2       (id_rd2),
    .id_imm       (id_imm),
    .id_alusrc    (id_alusrc),
    .id_operation (id_operation),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .ex_flush     (ex_flush),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .mem_result   (mem_result),
    .wb_result    (wb_result),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .Operation    (Operation),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .ex_store_data(ex_store_data),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic        alusrc;
    logic [3:0]  op;
    logic        regwrite, memread;
  } ex_t;

  ex_t m = '0;
  ex_t prev_m = '0;
  ex_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hazard();
    logic ex_hit, mem_hit;
    ex_hit  = (m.rd != 0) && ((m.rd == id_rs1) || (m.rd == id_rs2));
    mem_hit = (mem_rd != 0) && ((mem_rd == id_rs1) || (mem_rd == id_rs2));
`ifdef EX_FORWARDING_EN
    model_hazard = id_valid && m.valid && m.memread && ex_hit;
`else
    model_hazard = id_valid && ((m.regwrite && ex_hit) || (mem_regwrite && mem_hit));
`endif
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef EX_FORWARDING_EN
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return mem_result;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return wb_result;
`endif
    return rf;
  endfunction

  // One clock: check stall, push the expected next EX state, then compare outputs.
  task automatic cycle(output logic st);
    ex_t nx;
    logic s;
    #1;
    s  = model_hazard() && !ex_flush;
    st = stall;
    if (!reset) check_eq("stall", {31'b0, stall}, {31'b0, s});
    nx = '0;
    if (!reset && !ex_flush && !s) begin
      nx.valid    = id_valid;
      nx.rs1      = id_rs1;
      nx.rs2      = id_rs2;
      nx.rd       = id_rd;
      nx.rd1      = id_rd1;
      nx.rd2      = id_rd2;
      nx.imm      = id_imm;
      nx.alusrc   = id_alusrc;
      nx.op       = id_operation;
      nx.regwrite = id_valid && id_regwrite;
      nx.memread  = id_valid && id_memread;
    end
    exp_q.push_back(nx);
    @(posedge clk);
    prev_m = m;
    #1;
    m = exp_q.pop_front();
    check_eq("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    check_eq("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
    check_eq("ex_regwrite", {31'b0, ex_regwrite}, {31'b0, m.regwrite});
    check_eq("ex_memread", {31'b0, ex_memread}, {31'b0, m.memread});
    check_eq("Operation", {28'b0, Operation}, {28'b0, m.op});
    check_eq("SrcA", SrcA, fwd(m.rs1, m.rd1));
    check_eq("SrcB", SrcB, m.alusrc ? m.imm : fwd(m.rs2, m.rd2));
    check_eq("store_data", ex_store_data, fwd(m.rs2, m.rd2));
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic alusrc, input logic [3:0] op,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd1 = rd1; id_rd2 = rd2;
    id_imm = imm; id_alusrc = alusrc; id_operation = op; id_regwrite = rw; id_memread = mr;
  endtask

  // Advance the emulated MEM/WB stages by one instruction.
  task automatic pipe_shift();
    wb_rd = mem_rd; wb_regwrite = mem_regwrite; wb_result = mem_result;
    mem_rd = prev_m.rd; mem_regwrite = prev_m.regwrite; mem_result = $urandom;
  endtask

  task automatic idle_pipe();
    logic st;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pipe_shift();
      cycle(st);
    end
  endtask

  // Producer x5 (load or ALU op) followed by a dependent consumer.
  task automatic dep_test(input logic ld);
    logic st;
    int n;
    logic [31:0] ldv;
    idle_pipe();
    set_id(1, 1, 0, 5, 32'h9, 0, 32'h4, 1, 4'h2, 1, ld);
    pipe_shift();
    cycle(st);
    set_id(1, 5, 2, 7, 32'h1234, 32'h22, 0, 0, 4'h6, 1, 0);
    n = 0;
    ldv = 0;
    for (int i = 0; i < 5; i++) begin
      pipe_shift();
      if (mem_rd == 5) ldv = mem_result;
      cycle(st);
      if (!st) break;
      check_eq("bubble_valid", {31'b0, ex_valid}, 32'd0);
      n++;
    end
`ifdef EX_FORWARDING_EN
    check_eq(ld ? "ld_stall_cycles" : "alu_stall_cycles", n, ld ? 32'd1 : 32'd0);
    if (ld) check_eq("ld_fwd_srca", SrcA, ldv);
`else
    check_eq("dep_stall_cycles", n, 32'd2);
    check_eq("dep_srca_rf", SrcA, 32'h1234);
`endif
    check_eq("dep_loaded", {27'b0, ex_rd}, 32'd7);
  endtask

  initial begin
    logic st;
    reset = 1; ex_flush = 0;
    set_id(1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
           1'($urandom), 4'($urandom), 1, 1);
    mem_rd = 0; wb_rd = 0; mem_regwrite = 0; wb_regwrite = 0; mem_result = 0; wb_result = 0;
    cycle(st);
    cycle(st);
    reset = 0;
    check_eq("rst_srca", SrcA, 32'd0);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);

    // Forwarding priority.
    idle_pipe();
    set_id(1, 1, 2, 3, 5, 7, 0, 0, 4'h2, 1, 0);
    mem_regwrite = 0; wb_regwrite = 0;
    cycle(st);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_rd = 1; mem_result = 100; mem_regwrite = 1;
    wb_rd = 1; wb_result = 200; wb_regwrite = 1;
    #1;
`ifdef EX_FORWARDING_EN
    check_eq("prio_mem", SrcA, 32'd100);
    mem_regwrite = 0;
    #1;
    check_eq("prio_wb", SrcA, 32'd200);
`else
    check_eq("nofwd_srca", SrcA, 32'd5);
    mem_regwrite = 0;
    #1;
`endif
    check_eq("prio_srcb", SrcB, 32'd7);
    cycle(st);

    // Immediate operand and x0.
    mem_regwrite = 0; wb_regwrite = 0;
    set_id(1, 0, 4, 9, 32'h11, 32'h33, 32'hFFFF_FFF0, 1, 4'h2, 1, 0);
    cycle(st);
    mem_rd = 0; mem_regwrite = 1; mem_result = 55;
    #1;
    check_eq("imm_srcb", SrcB, 32'hFFFF_FFF0);
    check_eq("x0_srca", SrcA, 32'h11);
    mem_regwrite = 0;

    dep_test(1'b1);
    dep_test(1'b0);

    // Flush wins over a pending stall.
    idle_pipe();
    set_id(1, 1, 0, 5, 0, 0, 0, 1, 0, 1, 1);
    pipe_shift();
    cycle(st);
    set_id(1, 5, 1, 6, 0, 0, 0, 0, 0, 1, 0);
    ex_flush = 1;
    pipe_shift();
    cycle(st);
    check_eq("flush_stall", {31'b0, st}, 32'd0);
    check_eq("flush_bubble", {31'b0, ex_valid}, 32'd0);
    ex_flush = 0;

    // Reset during a stall.
    idle_pipe();
    set_id(1, 1, 0, 5, 0, 0, 0, 1, 0, 1, 1);
    pipe_shift();
    cycle(st);
    set_id(1, 5, 1, 6, 0, 0, 0, 0, 0, 1, 0);
    reset = 1;
    cycle(st);
    reset = 0;
    mem_regwrite = 0; wb_regwrite = 0;
    #1;
    check_eq("rst_mid_stall", {31'b0, stall}, 32'd0);
    cycle(st);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      ex_flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      pipe_shift();
      cycle(st);
    end
    reset = 0; ex_flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
